// File: rtl/mirror_pattern_counter.sv
// mirror_pattern_counter
// Produces a WIDTH-bit pattern with a mirrored pair of bits set, at
// positions pos and WIDTH-1-pos. The pair can move inward, move outward,
// bounce between the edge and the centre, or hold. An enable-driven
// prescaler sets the step rate. Other features are a position load and a
// one-cycle wrap pulse at the end of each sequence.
// Parameter legality: WIDTH must be even and >= 4, 2**POS_W >= WIDTH/2,
// and DIV >= 1. The design does not check these; the instantiating
// design must meet them.

module mirror_pattern_counter #(
    parameter int WIDTH = 8,
    parameter int POS_W = 2,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [POS_W-1:0] load_pos,
    output logic [WIDTH-1:0] pattern_out,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_INWARD  = 2'b00,
        MODE_OUTWARD = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_e;

    localparam int unsigned N     = WIDTH / 2;
    localparam int          PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [POS_W-1:0] POS_ZERO   = '0;
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(N - 1);
    localparam logic [POS_W-1:0] POS_PENULT = POS_W'(N - 2);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);

    mode_e            mode_s;
    logic [POS_W-1:0] pos_q, pos_d;
    dir_e             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [PRE_W-1:0] presc_q, presc_d;

    logic             counting;
    logic             tick;
    logic             pos_valid;
    logic             load_in_range;
    logic [POS_W-1:0] step_pos;
    dir_e             step_dir;
    logic             step_wrap;

    assign mode_s = mode_e'(mode);

    // Work out whether the prescaler is counting this cycle and whether it
    // completes a period. Hold mode freezes it in the same way enable=0 does.
    always_comb begin
        counting      = enable && (mode_s != MODE_HOLD);
        tick          = counting && (presc_q == PRE_LAST);
        pos_valid     = 32'(pos_q) < N;
        load_in_range = 32'(load_pos) < N;
    end

    // Compute the candidate position, direction and wrap for a tick in the
    // current mode. In bounce mode the pair reflects at either end without
    // repeating the endpoint. A full round trip ends on reaching position 0.
    always_comb begin
        step_pos  = pos_q;
        step_dir  = dir_q;
        step_wrap = 1'b0;
        case (mode_s)
            MODE_INWARD: begin
                if (pos_q == POS_LAST) begin
                    step_pos  = POS_ZERO;
                    step_wrap = 1'b1;
                end else begin
                    step_pos = pos_q + 1'b1;
                end
            end
            MODE_OUTWARD: begin
                if (pos_q == POS_ZERO) begin
                    step_pos  = POS_LAST;
                    step_wrap = 1'b1;
                end else begin
                    step_pos = pos_q - 1'b1;
                end
            end
            MODE_BOUNCE: begin
                if (dir_q == DIR_IN) begin
                    if (pos_q == POS_LAST) begin
                        step_dir = DIR_OUT;
                        step_pos = POS_PENULT;
                    end else begin
                        step_pos = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == POS_ZERO) begin
                        step_dir = DIR_IN;
                        step_pos = POS_ONE;
                    end else begin
                        step_pos = pos_q - 1'b1;
                    end
                end
                step_wrap = (step_pos == POS_ZERO);
            end
            default: begin
                step_pos  = pos_q;
                step_dir  = dir_q;
                step_wrap = 1'b0;
            end
        endcase
    end

    // Select the next state. Priority is load first, then recovery from an
    // out-of-range position (whatever enable and mode are), then a tick.
    // The prescaler keeps counting during recovery; only load clears it.
    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        presc_d = presc_q;
        if (counting) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (load) begin
            pos_d   = load_in_range ? load_pos : POS_ZERO;
            dir_d   = DIR_IN;
            presc_d = '0;
        end else if (!pos_valid) begin
            pos_d = POS_ZERO;
            dir_d = DIR_IN;
        end else if (tick) begin
            pos_d  = step_pos;
            dir_d  = step_dir;
            wrap_d = step_wrap;
        end
    end

    // State registers with synchronous clear, which takes priority over load.
    always_ff @(posedge clk) begin
        if (clear) begin
            pos_q   <= '0;
            dir_q   <= DIR_IN;
            wrap_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            presc_q <= presc_d;
        end
    end

    // Decode the registered position directly into the mirrored bit pair.
    always_comb begin
        pattern_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((32'(pos_q) == i) || (32'(pos_q) == (WIDTH - 1 - i))) begin
                pattern_out[i] = 1'b1;
            end
        end
    end

    assign pos  = pos_q;
    assign dir  = (dir_q == DIR_OUT);
    assign wrap = wrap_q;

endmodule
